// File: rtl/demux_rr_ctrl.sv
// Round-robin 1-to-8 demux controller: streams bursts of burst_len+1 words to each
// enabled channel in turn, with stall, abandon and async-reset handling.
module demux_rr_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       chan_mask,
  input  logic [2:0]       burst_len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [7:0]       out_ready,
  output logic [7:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic             burst_done
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] beat_q, beat_d;
  logic [2:0] limit_q, limit_d;
  logic       done_q, done_d;
  logic       run, chan_ok, xfer;

  // First set bit of mask at or above start, wrapping 7->0.
  function automatic logic [2:0] first_enabled(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    first_enabled = start;
    found         = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && mask[idx]) begin
        first_enabled = idx;
        found         = 1'b1;
      end
    end
  endfunction

  assign run      = en && (|chan_mask);
  assign chan_ok  = (state_q == StActive) && chan_mask[sel_q];
  assign in_ready = chan_ok && out_ready[sel_q];
  assign xfer     = in_valid && in_ready;

  always_comb begin
    out_valid = '0;
    if (chan_ok) begin
      out_valid = 8'(in_valid) << sel_q;
    end
  end

  assign out_data   = in_data;
  assign sel        = sel_q;
  assign burst_done = done_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StActive;
          sel_d   = first_enabled(chan_mask, sel_q);
          beat_d  = '0;
          limit_d = burst_len;
        end
      end
      StActive: begin
        if (!run) begin
          state_d = StIdle;
          beat_d  = '0;
        end else if (!chan_mask[sel_q]) begin
          // Channel disabled under us: drop the partial burst and move on silently.
          sel_d   = first_enabled(chan_mask, sel_q + 3'd1);
          beat_d  = '0;
          limit_d = burst_len;
        end else if (xfer) begin
          if (beat_q == limit_q) begin
            sel_d   = first_enabled(chan_mask, sel_q + 3'd1);
            beat_d  = '0;
            limit_d = burst_len;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      beat_q  <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed and randomized checks of demux_rr_ctrl against a cycle-level reference model.
module tb_demux_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] chan_mask;
  logic [2:0] burst_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       burst_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_act;
  int m_sel, m_beat, m_lim;
  bit m_done;

  always #5 clk = ~clk;

  demux_rr_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .chan_mask  (chan_mask),
    .burst_len  (burst_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sel        (sel),
    .burst_done (burst_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_en(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return start % 8;
  endfunction

  task automatic model_reset();
    m_act = 0; m_sel = 0; m_beat = 0; m_lim = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit nd;
    nd = 0;
    if (!m_act) begin
      if (en && chan_mask != 0) begin
        m_act = 1; m_sel = first_en(chan_mask, m_sel); m_beat = 0; m_lim = burst_len;
      end
    end else if (!en || chan_mask == 0) begin
      m_act = 0; m_beat = 0;
    end else if (!chan_mask[m_sel]) begin
      m_sel = first_en(chan_mask, m_sel + 1); m_beat = 0; m_lim = burst_len;
    end else if (in_valid && out_ready[m_sel]) begin
      if (m_beat == m_lim) begin
        m_sel = first_en(chan_mask, m_sel + 1); m_beat = 0; m_lim = burst_len; nd = 1;
      end else begin
        m_beat++;
      end
    end
    m_done = nd;
  endtask

  task automatic check_model();
    logic [7:0] ev;
    bit ok;
    ok = m_act && chan_mask[m_sel];
    ev = (ok && in_valid) ? 8'(1 << m_sel) : 8'h00;
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, ok && out_ready[m_sel]);
    chk("out_data", out_data, in_data);
    chk("sel", sel, m_sel);
    chk("burst_done", burst_done, m_done);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_sel", sel, 3'd0);
    chk("rst_burst_done", burst_done, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic flow(input logic [7:0] m, input logic [2:0] bl);
    en = 1'b1; chan_mask = m; burst_len = bl; in_valid = 1'b1; out_ready = 8'hFF;
  endtask

  initial begin
    int s33[10];
    s33 = '{2, 2, 2, 5, 5, 5, 7, 7, 7, 2};
    rst_n = 1'b0; en = 1'b0; chan_mask = '0; burst_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = '0;
    model_reset();
    @(negedge clk);

    // Full mask, single-word bursts
    do_reset();
    flow(8'hFF, 3'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      chk("r032_sel", sel, 32'(i % 8));
      chk("r032_done", burst_done, (i > 0) ? 1 : 0);
      tick();
    end

    // Sparse mask, 3-word bursts
    do_reset();
    flow(8'b1010_0100, 3'd2);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("r033_sel", sel, s33[i]);
      chk("r033_done", burst_done, (i > 0 && i % 3 == 0) ? 1 : 0);
      tick();
    end

    // Stall on channel 0
    do_reset();
    flow(8'hFF, 3'd3);
    out_ready = 8'hFE;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("r034_stall_ready", in_ready, 1'b0);
      chk("r034_stall_sel", sel, 3'd0);
      tick();
    end
    out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      chk("r034_sel", sel, 3'd0);
      tick();
    end
    chk("r034_next_sel", sel, 3'd1);
    chk("r034_done", burst_done, 1'b1);

    // Abandon mid-burst on channel 3
    do_reset();
    flow(8'hFF, 3'd3);
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("r035_pre_sel", sel, 3'd3);
    chan_mask = 8'hF7;
    #1;
    chk("r035_valid3", out_valid[3], 1'b0);
    chk("r035_ready", in_ready, 1'b0);
    tick();
    chk("r035_sel", sel, 3'd4);
    chk("r035_no_done", burst_done, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("r035_after_sel", sel, 3'd5);

    // Async reset mid-burst, single channel
    do_reset();
    flow(8'h10, 3'd1);
    tick();
    tick();
    chk("r036_pre_sel", sel, 3'd4);
    do_reset();
    tick();
    chk("r036_sel", sel, 3'd4);
    tick();
    chk("r036_done_early", burst_done, 1'b0);
    tick();
    chk("r036_done", burst_done, 1'b1);
    chk("r036_sel_hold", sel, 3'd4);

    // Randomized traffic
    do_reset();
    chan_mask = 8'($urandom);
    for (int c = 0; c < 500; c++) begin
      en        = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) chan_mask = 8'($urandom);
      if ($urandom_range(0, 29) == 0) chan_mask[$urandom_range(0, 7)] ^= 1'b1;
      burst_len = 3'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 79) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
